// File: rtl/data_cache_pkg.sv
// Shared line geometry, FSM encoding and line-word extraction for the L1 data cache.
package data_cache_pkg;
   localparam int DC_LINE_BITS = 256;
   localparam int DC_OFF_BITS  = 5;
   localparam int DC_WORDS     = DC_LINE_BITS / 32;

   typedef enum logic {
      DC_ST_IDLE = 1'b0,
      DC_ST_FILL = 1'b1
   } dc_state_e;

   // Big-endian line: word 0 sits in the most significant 32 bits.
   function automatic logic [31:0] dc_line_word(input logic [DC_LINE_BITS-1:0] line,
                                               input logic [2:0] w);
      return line[(DC_WORDS - 1 - int'(w)) * 32 +: 32];
   endfunction
endpackage

// File: rtl/data_cache_byte_merge.sv
// Combinational big-endian store merge into one 32-bit word; zero latency, no flow control.
// o_cross flags a store whose bytes run past the end of the word.
module data_cache_byte_merge (
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_data,
   output logic [31:0] o_word,
   output logic        o_cross
);
   int w_n;

   always_comb begin
      w_n     = (i_size == 2'd0) ? 4 : int'(i_size);
      o_word  = i_word;
      o_cross = (int'(i_off) + w_n) > 4;
      // Byte A+k of the store comes from data[8(n-k)-1 -: 8], MSB first.
      for (int b = 0; b < 4; b++) begin
         int k;
         k = b - int'(i_off);
         if (k >= 0 && k < w_n)
            o_word[(3 - b) * 8 +: 8] = i_data[(w_n - 1 - k) * 8 +: 8];
      end
   end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-allocate L1 D-cache: hits and stores complete same cycle,
// read misses stall (data_valid_fDC=0) until the line fill returns and the read re-hits.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int NUM_LINES = 64
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [31:0]             data_address_2DC,
   input  logic                    read_2DC,
   input  logic                    write_2DC,
   input  logic [31:0]             data_write_2DC,
   input  logic [1:0]              data_write_size_2DC,
   input  logic                    flush_2DC,
   output logic [31:0]             data_read_fDC,
   output logic                    data_valid_fDC,
   output logic [31:0]             data_address_2DM,
   output logic                    MemRead_2DM,
   output logic                    MemWrite_2DM,
   output logic [31:0]             data_write_2DM,
   output logic [1:0]              data_write_size_2DM,
   output logic                    dBlkRead,
   input  logic [DC_LINE_BITS-1:0] block_read_fDM,
   input  logic                    block_read_fDM_valid,
   output logic                    dBlkWrite,
   output logic [DC_LINE_BITS-1:0] block_write_2DM
);
   localparam int IDXB = $clog2(NUM_LINES);
   localparam int TAGW = 32 - DC_OFF_BITS - IDXB;

   dc_state_e                r_state, w_state_nxt;
   logic                     r_drop;
   logic [NUM_LINES-1:0]     r_valid;
   logic [TAGW-1:0]          r_tag  [NUM_LINES];
   logic [DC_LINE_BITS-1:0]  r_data [NUM_LINES];
   logic [31:DC_OFF_BITS]    r_fill_addr;

   logic [IDXB-1:0]          w_idx, w_fill_idx;
   logic [TAGW-1:0]          w_tag;
   logic                     w_hit, w_cross, w_install, w_wr_hit;
   logic [31:0]              w_word, w_merged;
   logic [DC_LINE_BITS-1:0]  w_line, w_new_line;

   assign w_idx      = data_address_2DC[DC_OFF_BITS +: IDXB];
   assign w_tag      = data_address_2DC[31 -: TAGW];
   assign w_fill_idx = r_fill_addr[DC_OFF_BITS +: IDXB];
   assign w_line     = r_data[w_idx];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_word     = dc_line_word(w_line, data_address_2DC[4:2]);
   assign w_wr_hit   = MemWrite_2DM && w_hit;
   // Flush in the fill-valid cycle, or any earlier flush (r_drop), discards the fill.
   assign w_install  = !RESET && (r_state == DC_ST_FILL) && block_read_fDM_valid
                       && !r_drop && !flush_2DC;

   data_cache_byte_merge u_merge (
      .i_word  (w_word),
      .i_off   (data_address_2DC[1:0]),
      .i_size  (data_write_size_2DC),
      .i_data  (data_write_2DC),
      .o_word  (w_merged),
      .o_cross (w_cross)
   );

   always_comb begin
      w_new_line = w_line;
      w_new_line[(DC_WORDS - 1 - int'(data_address_2DC[4:2])) * 32 +: 32] = w_merged;
   end

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= DC_ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      data_valid_fDC   = 1'b0;
      data_read_fDC    = 32'd0;
      MemWrite_2DM     = 1'b0;
      dBlkRead         = 1'b0;
      data_address_2DM = data_address_2DC;
      case (r_state)
         DC_ST_IDLE: begin
            if (!RESET && !flush_2DC) begin
               if (write_2DC) begin
                  MemWrite_2DM   = 1'b1;
                  data_valid_fDC = 1'b1;
               end else if (read_2DC) begin
                  if (w_hit) begin
                     data_valid_fDC = 1'b1;
                     data_read_fDC  = w_word;
                  end else begin
                     w_state_nxt = DC_ST_FILL;
                  end
               end
            end
         end
         DC_ST_FILL: begin
            if (!RESET) begin
               dBlkRead         = 1'b1;
               data_address_2DM = {r_fill_addr, {DC_OFF_BITS{1'b0}}};
               if (block_read_fDM_valid) w_state_nxt = DC_ST_IDLE;
            end
         end
         default: w_state_nxt = DC_ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= '0;
         r_drop  <= 1'b0;
      end else begin
         if (flush_2DC)                r_valid             <= '0;
         else if (w_install)           r_valid[w_fill_idx] <= 1'b1;
         else if (w_wr_hit && w_cross) r_valid[w_idx]      <= 1'b0;
         if (r_state == DC_ST_FILL) begin
            if (block_read_fDM_valid) r_drop <= 1'b0;
            else if (flush_2DC)       r_drop <= 1'b1;
         end
      end
   end

   // Fill address is captured so a withdrawn request still completes its fill.
   always_ff @(posedge CLK) begin
      if (r_state == DC_ST_IDLE && w_state_nxt == DC_ST_FILL)
         r_fill_addr <= data_address_2DC[31:DC_OFF_BITS];
      if (w_install) begin
         r_tag[w_fill_idx]  <= r_fill_addr[31 -: TAGW];
         r_data[w_fill_idx] <= block_read_fDM;
      end else if (w_wr_hit && !w_cross) begin
         r_data[w_idx] <= w_new_line;
      end
   end

   assign MemRead_2DM         = 1'b0;
   assign dBlkWrite           = 1'b0;
   assign block_write_2DM     = '0;
   assign data_write_2DM      = data_write_2DC;
   assign data_write_size_2DM = data_write_size_2DC;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector table for same-cycle hits/stores, hand sequences for fills.
module tb_data_cache;
   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  data_address_2DC, data_write_2DC;
   logic         read_2DC, write_2DC, flush_2DC;
   logic [1:0]   data_write_size_2DC;
   logic [31:0]  data_read_fDC, data_address_2DM, data_write_2DM;
   logic         data_valid_fDC, MemRead_2DM, MemWrite_2DM, dBlkRead, dBlkWrite;
   logic [1:0]   data_write_size_2DM;
   logic [255:0] block_read_fDM, block_write_2DM;
   logic         block_read_fDM_valid;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mem [bit [31:0]];

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [1:0]  sz;
      logic [31:0] exp;   // read data, or memory word after a store
   } vec_t;
   vec_t tv [14];

   always #5 CLK = ~CLK;

   data_cache #(.NUM_LINES(64)) dut (
      .CLK(CLK), .RESET(RESET),
      .data_address_2DC(data_address_2DC), .read_2DC(read_2DC), .write_2DC(write_2DC),
      .data_write_2DC(data_write_2DC), .data_write_size_2DC(data_write_size_2DC),
      .flush_2DC(flush_2DC), .data_read_fDC(data_read_fDC), .data_valid_fDC(data_valid_fDC),
      .data_address_2DM(data_address_2DM), .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
      .data_write_2DM(data_write_2DM), .data_write_size_2DM(data_write_size_2DM),
      .dBlkRead(dBlkRead), .block_read_fDM(block_read_fDM),
      .block_read_fDM_valid(block_read_fDM_valid), .dBlkWrite(dBlkWrite),
      .block_write_2DM(block_write_2DM)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'd0;
   endfunction

   function automatic logic [255:0] build_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[(7 - w) * 32 +: 32] = memrd(la + 32'(w * 4));
      return l;
   endfunction

   // Entered just after the edge that moved the DUT into FILL; leaves just after the fill edge.
   task automatic fill_wait(input string nm, input logic [31:0] la, input int lat);
      for (int c = 0; c < lat; c++) begin
         if (c == lat - 1) begin
            block_read_fDM       = build_line(la);
            block_read_fDM_valid = 1'b1;
         end
         smp();
         chk({nm, " fill dBlkRead"}, dBlkRead, 1'b1);
         chk({nm, " fill addr"}, data_address_2DM, la);
         chk({nm, " fill valid"}, data_valid_fDC, 1'b0);
         chk({nm, " fill memwrite"}, MemWrite_2DM, 1'b0);
         tick();
      end
      block_read_fDM_valid = 1'b0;
      block_read_fDM       = '0;
   endtask

   task automatic read_miss(input string nm, input logic [31:0] a, input int lat,
                            input logic [31:0] exp);
      read_2DC = 1'b1; write_2DC = 1'b0; data_address_2DC = a;
      smp();
      chk({nm, " miss valid"}, data_valid_fDC, 1'b0);
      chk({nm, " miss dBlkRead"}, dBlkRead, 1'b0);
      tick();
      fill_wait(nm, {a[31:5], 5'b0}, lat);
      smp();
      chk({nm, " after-fill valid"}, data_valid_fDC, 1'b1);
      chk({nm, " after-fill data"}, data_read_fDC, exp);
      chk({nm, " after-fill dBlkRead"}, dBlkRead, 1'b0);
      tick();
      read_2DC = 1'b0;
   endtask

   task automatic read_hit(input string nm, input logic [31:0] a, input logic [31:0] exp);
      read_2DC = 1'b1; write_2DC = 1'b0; data_address_2DC = a;
      smp();
      chk({nm, " hit valid"}, data_valid_fDC, 1'b1);
      chk({nm, " hit data"}, data_read_fDC, exp);
      chk({nm, " hit dBlkRead"}, dBlkRead, 1'b0);
      tick();
      read_2DC = 1'b0;
   endtask

   task automatic store(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic [31:0] mem_after);
      read_2DC = 1'b0; write_2DC = 1'b1; data_address_2DC = a;
      data_write_2DC = d; data_write_size_2DC = sz;
      smp();
      chk({nm, " st valid"}, data_valid_fDC, 1'b1);
      chk({nm, " st memwrite"}, MemWrite_2DM, 1'b1);
      chk({nm, " st addr"}, data_address_2DM, a);
      chk({nm, " st data"}, data_write_2DM, d);
      chk({nm, " st size"}, data_write_size_2DM, sz);
      tick();
      write_2DC = 1'b0;
      mem[{a[31:2], 2'b00}] = mem_after;
   endtask

   initial begin
      tv[0]  = '{1'b0, 1'b1, 32'h1000_0041, 32'h0000_00AB, 2'd1, 32'hDEAB_BEEF};
      tv[1]  = '{1'b1, 1'b0, 32'h1000_0040, 32'h0,         2'd0, 32'hDEAB_BEEF};
      tv[2]  = '{1'b0, 1'b1, 32'h1000_0046, 32'h0000_CAFE, 2'd2, 32'h1122_CAFE};
      tv[3]  = '{1'b1, 1'b0, 32'h1000_0044, 32'h0,         2'd0, 32'h1122_CAFE};
      tv[4]  = '{1'b0, 1'b1, 32'h1000_0049, 32'h00A1_B2C3, 2'd3, 32'h55A1_B2C3};
      tv[5]  = '{1'b1, 1'b0, 32'h1000_004A, 32'h0,         2'd0, 32'h55A1_B2C3};
      tv[6]  = '{1'b1, 1'b1, 32'h1000_004C, 32'hCAFE_BABE, 2'd0, 32'hCAFE_BABE};
      tv[7]  = '{1'b1, 1'b0, 32'h1000_004C, 32'h0,         2'd0, 32'hCAFE_BABE};
      tv[8]  = '{1'b0, 1'b1, 32'h1000_0043, 32'h1234_5677, 2'd1, 32'hDEAB_BE77};
      tv[9]  = '{1'b0, 1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF};
      tv[10] = '{1'b1, 1'b0, 32'h1000_0040, 32'h0,         2'd0, 32'hDEAB_BE77};
      tv[11] = '{1'b0, 1'b1, 32'h1000_0044, 32'h0000_1234, 2'd2, 32'h1234_CAFE};
      tv[12] = '{1'b1, 1'b0, 32'h1000_0044, 32'h0,         2'd0, 32'h1234_CAFE};
      tv[13] = '{1'b1, 1'b0, 32'h1000_0048, 32'h0,         2'd0, 32'h55A1_B2C3};

      mem[32'h1000_0040] = 32'hDEAD_BEEF;
      mem[32'h1000_0044] = 32'h1122_3344;
      mem[32'h1000_0048] = 32'h5566_7788;
      mem[32'h1000_004C] = 32'h99AA_BBCC;
      mem[32'h0000_0000] = 32'hA0A0_0000;
      mem[32'h0000_0800] = 32'h0800_0800;
      mem[32'h0000_0C04] = 32'h0C04_CAFE;
      mem[32'h0000_0100] = 32'h0100_AAAA;
      mem[32'h0000_0200] = 32'h0200_BBBB;

      RESET = 1'b1; read_2DC = 1'b0; write_2DC = 1'b0; flush_2DC = 1'b0;
      data_address_2DC = '0; data_write_2DC = '0; data_write_size_2DC = '0;
      block_read_fDM = '0; block_read_fDM_valid = 1'b0;

      smp();
      chk("rst valid", data_valid_fDC, 1'b0);
      chk("rst dBlkRead", dBlkRead, 1'b0);
      chk("rst memwrite", MemWrite_2DM, 1'b0);
      chk("rst rdata", data_read_fDC, 32'd0);
      tick();
      RESET = 1'b0;
      smp();
      chk("idle valid", data_valid_fDC, 1'b0);
      chk("idle dBlkRead", dBlkRead, 1'b0);
      tick();

      read_miss("t1", 32'h1000_0040, 3, 32'hDEAD_BEEF);
      read_hit("t1 reread", 32'h1000_0040, 32'hDEAD_BEEF);

      for (int i = 0; i < 14; i++) begin
         read_2DC = tv[i].rd; write_2DC = tv[i].wr; data_address_2DC = tv[i].addr;
         data_write_2DC = tv[i].wdat; data_write_size_2DC = tv[i].sz;
         smp();
         chk($sformatf("vec%0d valid", i), data_valid_fDC, 1'b1);
         chk($sformatf("vec%0d dBlkRead", i), dBlkRead, 1'b0);
         if (tv[i].wr) begin
            chk($sformatf("vec%0d memwrite", i), MemWrite_2DM, 1'b1);
            chk($sformatf("vec%0d st data", i), data_write_2DM, tv[i].wdat);
            chk($sformatf("vec%0d st size", i), data_write_size_2DM, tv[i].sz);
            chk($sformatf("vec%0d st addr", i), data_address_2DM, tv[i].addr);
         end else begin
            chk($sformatf("vec%0d memwrite", i), MemWrite_2DM, 1'b0);
            chk($sformatf("vec%0d rdata", i), data_read_fDC, tv[i].exp);
         end
         tick();
         if (tv[i].wr) mem[{tv[i].addr[31:2], 2'b00}] = tv[i].exp;
      end
      read_2DC = 1'b0; write_2DC = 1'b0;

      // Word-crossing store is forwarded and kills the cached line.
      store("cross", 32'h1000_005F, 32'h0000_BEEF, 2'd2, 32'h0000_0000);
      read_miss("cross", 32'h1000_0040, 2, 32'hDEAB_BE77);

      store("t3", 32'h2000_0000, 32'h1234_5678, 2'd0, 32'h1234_5678);
      read_miss("t3", 32'h2000_0000, 2, 32'h1234_5678);

      read_miss("t4a", 32'h0000_0000, 1, 32'hA0A0_0000);
      read_miss("t4b", 32'h0000_0800, 2, 32'h0800_0800);
      read_miss("t4c", 32'h0000_0000, 1, 32'hA0A0_0000);

      // Request withdrawn (and a store presented) mid-fill: no store strobe, line still installed.
      read_2DC = 1'b1; data_address_2DC = 32'h0000_0C04;
      smp();
      chk("wd miss valid", data_valid_fDC, 1'b0);
      tick();
      read_2DC = 1'b0; write_2DC = 1'b1; data_address_2DC = 32'h0000_0C44;
      data_write_2DC = 32'hFFFF_FFFF; data_write_size_2DC = 2'd0;
      smp();
      chk("wd fill memwrite", MemWrite_2DM, 1'b0);
      chk("wd fill valid", data_valid_fDC, 1'b0);
      chk("wd fill dBlkRead", dBlkRead, 1'b1);
      chk("wd fill addr", data_address_2DM, 32'h0000_0C00);
      tick();
      write_2DC = 1'b0;
      fill_wait("wd", 32'h0000_0C00, 2);
      read_hit("wd installed", 32'h0000_0C04, 32'h0C04_CAFE);

      // Flush during FILL: handshake completes, line dropped, re-read misses.
      read_2DC = 1'b1; data_address_2DC = 32'h0000_0100;
      smp();
      chk("t5 miss valid", data_valid_fDC, 1'b0);
      tick();
      flush_2DC = 1'b1;
      smp();
      chk("t5 flush dBlkRead", dBlkRead, 1'b1);
      chk("t5 flush valid", data_valid_fDC, 1'b0);
      tick();
      flush_2DC = 1'b0;
      fill_wait("t5", 32'h0000_0100, 2);
      read_miss("t5 refetch", 32'h0000_0100, 2, 32'h0100_AAAA);
      read_miss("t5 flushed", 32'h0000_0C04, 1, 32'h0C04_CAFE);

      // Flush in IDLE on a would-be hit.
      read_2DC = 1'b1; flush_2DC = 1'b1; data_address_2DC = 32'h0000_0100;
      smp();
      chk("idle flush valid", data_valid_fDC, 1'b0);
      tick();
      flush_2DC = 1'b0;
      read_miss("idle flush", 32'h0000_0100, 1, 32'h0100_AAAA);

      // Reset in the middle of a fill.
      read_2DC = 1'b1; data_address_2DC = 32'h0000_0200;
      smp();
      chk("t6 miss valid", data_valid_fDC, 1'b0);
      tick();
      smp();
      chk("t6 fill dBlkRead", dBlkRead, 1'b1);
      tick();
      RESET = 1'b1;
      smp();
      tick();
      RESET = 1'b0; read_2DC = 1'b0;
      smp();
      chk("t6 post-rst dBlkRead", dBlkRead, 1'b0);
      chk("t6 post-rst valid", data_valid_fDC, 1'b0);
      tick();
      read_miss("t6 lost", 32'h0000_0100, 2, 32'h0100_AAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
